// File: rtl/alu_share_arb_if.sv
// Request/steer/response bundle between the two ALU requesters, the shared
// ALU/decoder, and the alu_share_arb arbiter.
interface alu_share_arb_if #(parameter int unsigned XLEN = 32);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [6:0]      req_opcode0, req_opcode1;
  logic [2:0]      req_funct0,  req_funct1;
  logic            req_art0,    req_art1;
  logic [XLEN-1:0] req_a0, req_b0, req_a1, req_b1;

  logic [6:0]      dec_opcode;
  logic [2:0]      dec_funct;
  logic            dec_art;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [XLEN-1:0] alu_result;

  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [XLEN-1:0] resp_data0, resp_data1;

  // Arbiter side
  modport slave (
    input  req_valid, req_opcode0, req_opcode1, req_funct0, req_funct1,
           req_art0, req_art1, req_a0, req_b0, req_a1, req_b1,
           alu_result, resp_ready,
    output req_ready, dec_opcode, dec_funct, dec_art, alu_a, alu_b,
           resp_valid, resp_data0, resp_data1
  );

  // Requesters plus the ALU itself
  modport master (
    output req_valid, req_opcode0, req_opcode1, req_funct0, req_funct1,
           req_art0, req_art1, req_a0, req_b0, req_a1, req_b1,
           alu_result, resp_ready,
    input  req_ready, dec_opcode, dec_funct, dec_art, alu_a, alu_b,
           resp_valid, resp_data0, resp_data1
  );
endinterface

// File: rtl/alu_share_arb.sv
// Time-shares one ALU/decoder between two requesters, with a one-entry response
// buffer each. Round-robin; define ALU_SHARE_FIXED_PRIO_EN for fixed priority to 0.
module alu_share_arb #(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            reset_n,
  alu_share_arb_if.slave bus
);

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;

  buf_state_t      buf_state [2];
  logic [XLEN-1:0] resp_data_q [2];
  logic [1:0]      full;
  logic [1:0]      elig;
  logic [1:0]      grant;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic            last_grant;
`endif

  always_comb begin
    full[0] = (buf_state[0] == BUF_FULL);
    full[1] = (buf_state[1] == BUF_FULL);
    // A full buffer that drains this cycle can take a new result now
    elig    = bus.req_valid & (~full | bus.resp_ready);
    grant   = '0;
    if (elig == 2'b11) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      grant = 2'b01;
`else
      grant = last_grant ? 2'b01 : 2'b10;
`endif
    end else if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    bus.req_ready  = grant;
    bus.dec_opcode = '0;
    bus.dec_funct  = '0;
    bus.dec_art    = 1'b0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    case (grant)
      2'b01: begin
        bus.dec_opcode = bus.req_opcode0;
        bus.dec_funct  = bus.req_funct0;
        bus.dec_art    = bus.req_art0;
        bus.alu_a      = bus.req_a0;
        bus.alu_b      = bus.req_b0;
      end
      2'b10: begin
        bus.dec_opcode = bus.req_opcode1;
        bus.dec_funct  = bus.req_funct1;
        bus.dec_art    = bus.req_art1;
        bus.alu_a      = bus.req_a1;
        bus.alu_b      = bus.req_b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.resp_valid = full;
    bus.resp_data0 = resp_data_q[0];
    bus.resp_data1 = resp_data_q[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        buf_state[i]   <= BUF_EMPTY;
        resp_data_q[i] <= '0;
      end
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i]) begin
          buf_state[i]   <= BUF_FULL;
          resp_data_q[i] <= bus.alu_result;
        end else if (buf_state[i] == BUF_FULL && bus.resp_ready[i]) begin
          buf_state[i]   <= BUF_EMPTY;
        end
      end
`ifndef ALU_SHARE_FIXED_PRIO_EN
      if (grant != 2'b00) last_grant <= grant[1];
`endif
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: stateful vector table plus hand sequences
// for round-robin from reset and asynchronous reset with full buffers.
module tb_alu_share_arb;

  localparam logic [6:0] OPC_RT  = 7'b0110011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_share_arb_if #(.XLEN(32)) bus ();

  alu_share_arb #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic logic [31:0] alu_model(input logic [6:0] opc, input logic [2:0] fn,
                                            input logic art, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (opc == OPC_RT) begin
      case (fn)
        3'b000:  r = art ? (a - b) : (a + b);
        3'b100:  r = a ^ b;
        3'b110:  r = a | b;
        3'b111:  r = a & b;
        default: r = '0;
      endcase
    end else if (opc == OPC_LUI) begin
      r = b;
    end
    return r;
  endfunction

  assign bus.alu_result = alu_model(bus.dec_opcode, bus.dec_funct, bus.dec_art,
                                    bus.alu_a, bus.alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rready;
    logic [6:0]  opc0;
    logic [2:0]  fn0;
    logic        art0;
    logic [31:0] a0, b0;
    logic [6:0]  opc1;
    logic [2:0]  fn1;
    logic        art1;
    logic [31:0] a1, b1;
    logic [1:0]  exp_ready;
    logic [6:0]  exp_opc;
    logic [31:0] exp_alu_a, exp_alu_b;
    logic [1:0]  exp_rvalid;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  vec_t vecs [11];

  task automatic drive(input vec_t v);
    bus.req_valid   = v.valid;
    bus.resp_ready  = v.rready;
    bus.req_opcode0 = v.opc0;
    bus.req_funct0  = v.fn0;
    bus.req_art0    = v.art0;
    bus.req_a0      = v.a0;
    bus.req_b0      = v.b0;
    bus.req_opcode1 = v.opc1;
    bus.req_funct1  = v.fn1;
    bus.req_art1    = v.art1;
    bus.req_a1      = v.a1;
    bus.req_b1      = v.b1;
  endtask

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] rready,
                              input logic [6:0] opc0, input logic [2:0] fn0, input logic art0,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic [6:0] opc1, input logic [2:0] fn1, input logic art1,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic [1:0] er, input logic [6:0] eo,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [1:0] ev, input logic [31:0] ed0,
                              input logic [31:0] ed1);
    vec_t v;
    v.valid = valid; v.rready = rready;
    v.opc0 = opc0; v.fn0 = fn0; v.art0 = art0; v.a0 = a0; v.b0 = b0;
    v.opc1 = opc1; v.fn1 = fn1; v.art1 = art1; v.a1 = a1; v.b1 = b1;
    v.exp_ready = er; v.exp_opc = eo; v.exp_alu_a = ea; v.exp_alu_b = eb;
    v.exp_rvalid = ev; v.exp_d0 = ed0; v.exp_d1 = ed1;
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    drive(mk(2'b00, 2'b00, '0, '0, 0, '0, '0, '0, '0, 0, '0, '0, '0, '0, '0, '0, '0, '0, '0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [1:0] exp_grants [4];

  initial begin
    // Stateful sequence from reset; round-robin pointer starts favouring requester 0
    vecs[0]  = mk(2'b00, 2'b00, OPC_RT, 3'd0, 0, 32'd0, 32'd0, OPC_RT, 3'd0, 0, 32'd0, 32'd0,
                  2'b00, 7'd0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0);
    vecs[1]  = mk(2'b01, 2'b00, OPC_RT, 3'd0, 0, 32'd5, 32'd7, OPC_RT, 3'd0, 0, 32'd0, 32'd0,
                  2'b01, OPC_RT, 32'd5, 32'd7, 2'b01, 32'd12, 32'd0);
    vecs[2]  = mk(2'b00, 2'b01, OPC_RT, 3'd0, 0, 32'd0, 32'd0, OPC_RT, 3'd0, 0, 32'd0, 32'd0,
                  2'b00, 7'd0, 32'd0, 32'd0, 2'b00, 32'd12, 32'd0);
    vecs[3]  = mk(2'b11, 2'b11, OPC_RT, 3'd0, 1, 32'd10, 32'd3, OPC_RT, 3'd4, 0, 32'hF0, 32'h0F,
                  2'b10, OPC_RT, 32'hF0, 32'h0F, 2'b10, 32'd12, 32'hFF);
    vecs[4]  = mk(2'b11, 2'b11, OPC_RT, 3'd0, 1, 32'd10, 32'd3, OPC_RT, 3'd4, 0, 32'hF0, 32'h0F,
                  2'b01, OPC_RT, 32'd10, 32'd3, 2'b01, 32'd7, 32'hFF);
    vecs[5]  = mk(2'b10, 2'b01, OPC_RT, 3'd0, 0, 32'd0, 32'd0, OPC_RT, 3'd4, 0, 32'hF0, 32'h0F,
                  2'b10, OPC_RT, 32'hF0, 32'h0F, 2'b10, 32'd7, 32'hFF);
    vecs[6]  = mk(2'b01, 2'b00, OPC_RT, 3'd0, 0, 32'd1, 32'd2, OPC_RT, 3'd0, 0, 32'd0, 32'd0,
                  2'b01, OPC_RT, 32'd1, 32'd2, 2'b11, 32'd3, 32'hFF);
    vecs[7]  = mk(2'b01, 2'b01, OPC_LUI, 3'd0, 0, 32'd0, 32'h12345000, OPC_RT, 3'd0, 0, 32'd0, 32'd0,
                  2'b01, OPC_LUI, 32'd0, 32'h12345000, 2'b11, 32'h12345000, 32'hFF);
    vecs[8]  = mk(2'b11, 2'b01, OPC_RT, 3'd0, 0, 32'd4, 32'd4, OPC_RT, 3'd0, 0, 32'd100, 32'd1,
                  2'b01, OPC_RT, 32'd4, 32'd4, 2'b11, 32'd8, 32'hFF);
    vecs[9]  = mk(2'b11, 2'b11, OPC_RT, 3'd0, 0, 32'd4, 32'd4, OPC_RT, 3'd0, 0, 32'd100, 32'd1,
                  2'b10, OPC_RT, 32'd100, 32'd1, 2'b10, 32'd8, 32'd101);
    vecs[10] = mk(2'b00, 2'b10, OPC_RT, 3'd0, 0, 32'd0, 32'd0, OPC_RT, 3'd0, 0, 32'd0, 32'd0,
                  2'b00, 7'd0, 32'd0, 32'd0, 2'b00, 32'd8, 32'd101);

    reset_n = 1'b0;
    drive(vecs[0]);
    #2;
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_data0", bus.resp_data0, 32'd0);
    check("reset resp_data1", bus.resp_data1, 32'd0);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d dec_opcode", i), 32'(bus.dec_opcode), 32'(vecs[i].exp_opc));
      check($sformatf("v%0d alu_a", i), bus.alu_a, vecs[i].exp_alu_a);
      check($sformatf("v%0d alu_b", i), bus.alu_b, vecs[i].exp_alu_b);
      @(posedge clk);
      #1;
      check($sformatf("v%0d resp_valid", i), 32'(bus.resp_valid), 32'(vecs[i].exp_rvalid));
      check($sformatf("v%0d resp_data0", i), bus.resp_data0, vecs[i].exp_d0);
      check($sformatf("v%0d resp_data1", i), bus.resp_data1, vecs[i].exp_d1);
    end

    // Contention from reset with both responses always drained
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_grants[0] = 2'b01; exp_grants[1] = 2'b01; exp_grants[2] = 2'b01; exp_grants[3] = 2'b01;
`else
    exp_grants[0] = 2'b01; exp_grants[1] = 2'b10; exp_grants[2] = 2'b01; exp_grants[3] = 2'b10;
`endif
    do_reset();
    drive(mk(2'b11, 2'b11, OPC_RT, 3'd0, 0, 32'd1, 32'd1, OPC_RT, 3'd0, 0, 32'd2, 32'd2,
             '0, '0, '0, '0, '0, '0, '0));
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr cycle%0d grant", c), 32'(bus.req_ready), 32'(exp_grants[c]));
      @(negedge clk);
    end

    // Fill both buffers, then reset asynchronously between clock edges
    do_reset();
    drive(mk(2'b11, 2'b00, OPC_RT, 3'd0, 0, 32'd3, 32'd4, OPC_RT, 3'd0, 0, 32'd5, 32'd6,
             '0, '0, '0, '0, '0, '0, '0));
    @(negedge clk);
    #1;
    check("fill second grant", 32'(bus.req_ready), 32'b10);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("full resp_valid", 32'(bus.resp_valid), 32'b11);
    check("full resp_data0", bus.resp_data0, 32'd7);
    check("full resp_data1", bus.resp_data1, 32'd11);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("async rst resp_data0", bus.resp_data0, 32'd0);
    check("async rst resp_data1", bus.resp_data1, 32'd0);
    check("async rst req_ready", 32'(bus.req_ready), 32'd0);

    // After release, contention restarts from the reset pointer
    @(negedge clk);
    reset_n = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("post rst grant", 32'(bus.req_ready), 32'b01);
    check("post rst alu_a", bus.alu_a, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
